// File: rtl/melody_pkg.sv
// Shared widths, note/duration constants, FSM states and the note record
// used by the melody sequencer and its note table.
package melody_pkg;

    localparam int PITCH_BITWIDTH = 9;
    localparam int DUR_BITWIDTH   = 13;
    localparam int ADDR_BITWIDTH  = 5;
    localparam int TABLE_DEPTH    = 1 << ADDR_BITWIDTH;

    // Silence between notes, only used when MELODY_SEQ_GAP_EN is defined.
    localparam int GAP_TICKS    = 200;
    localparam int GAP_BITWIDTH = $clog2(GAP_TICKS + 1);

    localparam logic [PITCH_BITWIDTH-1:0] NOTE_D     = 9'd266;
    localparam logic [PITCH_BITWIDTH-1:0] NOTE_E     = 9'd237;
    localparam logic [PITCH_BITWIDTH-1:0] NOTE_FIS   = 9'd211;
    localparam logic [PITCH_BITWIDTH-1:0] NOTE_G     = 9'd199;
    localparam logic [PITCH_BITWIDTH-1:0] NOTE_A     = 9'd177;
    localparam logic [PITCH_BITWIDTH-1:0] NOTE_B     = 9'd158;
    localparam logic [PITCH_BITWIDTH-1:0] NOTE_C     = 9'd149;
    localparam logic [PITCH_BITWIDTH-1:0] NOTE_DHIGH = 9'd133;

    localparam logic [DUR_BITWIDTH-1:0] DUR_HALF         = 13'd8000;
    localparam logic [DUR_BITWIDTH-1:0] DUR_DOTTED_QUART = 13'd6000;
    localparam logic [DUR_BITWIDTH-1:0] DUR_QUARTER      = 13'd4000;
    localparam logic [DUR_BITWIDTH-1:0] DUR_EIGHTH       = 13'd2000;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    typedef struct packed {
        logic [PITCH_BITWIDTH-1:0] pitch;
        logic [DUR_BITWIDTH-1:0]   dur;
    } note_t;

    // A zero duration would never reach the end-of-note condition, so it plays as one tick.
    function automatic logic [DUR_BITWIDTH-1:0] eff_dur(input logic [DUR_BITWIDTH-1:0] d);
        return (d == '0) ? DUR_BITWIDTH'(1) : d;
    endfunction

endpackage

// File: rtl/note_table.sv
// 32-entry note register file: synchronous write, asynchronous read.
module note_table
    import melody_pkg::*;
(
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [ADDR_BITWIDTH-1:0]  wr_addr,
    input  logic [PITCH_BITWIDTH-1:0] wr_pitch,
    input  logic [DUR_BITWIDTH-1:0]   wr_dur,
    input  logic [ADDR_BITWIDTH-1:0]  rd_addr,
    output logic [PITCH_BITWIDTH-1:0] rd_pitch,
    output logic [DUR_BITWIDTH-1:0]   rd_dur
);

    note_t mem [TABLE_DEPTH];

    // NOTE: storage arrays get no reset; the host owns their contents and a reset must not erase a loaded melody.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= '{pitch: wr_pitch, dur: wr_dur};
        end
    end

    assign rd_pitch = mem[rd_addr].pitch;
    assign rd_dur   = mem[rd_addr].dur;

endmodule

// File: rtl/melody_sequencer.sv
// Table-driven note sequencer feeding the sine clkgen pitch input on fs ticks.
// Define MELODY_SEQ_GAP_EN to insert GAP_TICKS of silence between notes.
module melody_sequencer
    import melody_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fs_tick,
    input  logic                      wr_en,
    input  logic [ADDR_BITWIDTH-1:0]  wr_addr,
    input  logic [PITCH_BITWIDTH-1:0] wr_pitch,
    input  logic [DUR_BITWIDTH-1:0]   wr_dur,
    input  logic [ADDR_BITWIDTH:0]    len,
    input  logic                      loop_en,
    input  logic                      start,
    input  logic                      stop,
    output logic [PITCH_BITWIDTH-1:0] pitch,
    output logic                      note_start,
    output logic [ADDR_BITWIDTH-1:0]  note_idx,
    output logic                      busy,
    output logic                      done
);

    state_t                    state, next_state;
    logic [DUR_BITWIDTH-1:0]   remaining;
    logic [ADDR_BITWIDTH:0]    len_q;
    logic [PITCH_BITWIDTH-1:0] rd_pitch;
    logic [DUR_BITWIDTH-1:0]   rd_dur;
    logic                      start_ok, note_end, last_note;
`ifdef MELODY_SEQ_GAP_EN
    logic [GAP_BITWIDTH-1:0]   gap_cnt;
    logic                      gap_end;
`endif

    note_table u_note_table (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_pitch (wr_pitch),
        .wr_dur   (wr_dur),
        .rd_addr  (note_idx),
        .rd_pitch (rd_pitch),
        .rd_dur   (rd_dur)
    );

    assign start_ok  = start && (len != '0) && (len <= (ADDR_BITWIDTH+1)'(TABLE_DEPTH));
    assign note_end  = (state == PLAY) && fs_tick && (remaining == DUR_BITWIDTH'(1));
    assign last_note = ({1'b0, note_idx} == (len_q - (ADDR_BITWIDTH+1)'(1)));
`ifdef MELODY_SEQ_GAP_EN
    assign gap_end   = (state == GAP) && fs_tick && (gap_cnt == GAP_BITWIDTH'(1));
`endif

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_ok) next_state = LOAD;
            LOAD: next_state = PLAY;
            PLAY: begin
                if (note_end) begin
                    if (last_note && !loop_en) begin
                        next_state = IDLE;
                    end else begin
`ifdef MELODY_SEQ_GAP_EN
                        next_state = GAP;
`else
                        next_state = LOAD;
`endif
                    end
                end
            end
`ifdef MELODY_SEQ_GAP_EN
            GAP: if (gap_end) next_state = LOAD;
`endif
            default: next_state = IDLE;
        endcase
        // stop overrides everything, including a simultaneous start
        if (stop) next_state = IDLE;
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pitch      <= '0;
            note_start <= 1'b0;
            note_idx   <= '0;
            done       <= 1'b0;
            remaining  <= '0;
            len_q      <= '0;
`ifdef MELODY_SEQ_GAP_EN
            gap_cnt    <= '0;
`endif
        end else begin
            note_start <= 1'b0;
            done       <= 1'b0;
            if (stop) begin
                pitch    <= '0;
                note_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            len_q    <= len;
                            note_idx <= '0;
                        end
                    end
                    LOAD: begin
                        pitch      <= rd_pitch;
                        remaining  <= eff_dur(rd_dur);
                        note_start <= 1'b1;
                    end
                    PLAY: begin
                        if (fs_tick && (remaining != '0)) begin
                            remaining <= remaining - DUR_BITWIDTH'(1);
                        end
                        if (note_end) begin
                            if (!last_note) begin
                                note_idx <= note_idx + ADDR_BITWIDTH'(1);
                            end else if (loop_en) begin
                                note_idx <= '0;
                            end else begin
                                pitch    <= '0;
                                done     <= 1'b1;
                                note_idx <= '0;
                            end
`ifdef MELODY_SEQ_GAP_EN
                            if (!last_note || loop_en) begin
                                pitch   <= '0;
                                gap_cnt <= GAP_BITWIDTH'(GAP_TICKS);
                            end
`endif
                        end
                    end
`ifdef MELODY_SEQ_GAP_EN
                    GAP: begin
                        if (fs_tick && (gap_cnt != '0)) begin
                            gap_cnt <= gap_cnt - GAP_BITWIDTH'(1);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: start/stop vector table, directed
// melodies, async reset, and random melodies against a per-tick pitch model.
module tb_melody_sequencer;
    import melody_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      fs_tick = 1'b0;
    logic                      wr_en = 1'b0;
    logic [ADDR_BITWIDTH-1:0]  wr_addr = '0;
    logic [PITCH_BITWIDTH-1:0] wr_pitch = '0;
    logic [DUR_BITWIDTH-1:0]   wr_dur = '0;
    logic [ADDR_BITWIDTH:0]    len = '0;
    logic                      loop_en = 1'b0;
    logic                      start = 1'b0;
    logic                      stop = 1'b0;
    logic [PITCH_BITWIDTH-1:0] pitch;
    logic                      note_start;
    logic [ADDR_BITWIDTH-1:0]  note_idx;
    logic                      busy;
    logic                      done;

    melody_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .fs_tick    (fs_tick),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_pitch   (wr_pitch),
        .wr_dur     (wr_dur),
        .len        (len),
        .loop_en    (loop_en),
        .start      (start),
        .stop       (stop),
        .pitch      (pitch),
        .note_start (note_start),
        .note_idx   (note_idx),
        .busy       (busy),
        .done       (done)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ns_cnt   = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (note_start === 1'b1) ns_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    // Reference: host-side copy of the table and the expected pitch/index per fs-tick slot.
    note_t model [TABLE_DEPTH];
    int    exp_p [$];
    int    exp_i [$];

    typedef struct {
        logic [ADDR_BITWIDTH:0] len;
        logic                   stop;
        logic                   exp_busy;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic tick();
        fs_tick = 1'b1;
        cycle();
        fs_tick = 1'b0;
        repeat (9) cycle();
    endtask

    task automatic write_note(input int a, input int p, input int d);
        wr_en    = 1'b1;
        wr_addr  = ADDR_BITWIDTH'(a);
        wr_pitch = PITCH_BITWIDTH'(p);
        wr_dur   = DUR_BITWIDTH'(d);
        cycle();
        wr_en = 1'b0;
        model[a].pitch = PITCH_BITWIDTH'(p);
        model[a].dur   = DUR_BITWIDTH'(d);
    endtask

    // Each note contributes max(dur,1) slots of its pitch; the melody repeats 'passes' times.
    function automatic void expand(input int n, input int passes);
        exp_p.delete();
        exp_i.delete();
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < n; i++) begin
                int d;
                d = (model[i].dur == 0) ? 1 : int'(model[i].dur);
                for (int k = 0; k < d; k++) begin
                    exp_p.push_back(int'(model[i].pitch));
                    exp_i.push_back(i);
                end
            end
        end
    endfunction

    task automatic play(input int n_len, input bit lp, input int clear_at, input string tag);
        len     = (ADDR_BITWIDTH+1)'(n_len);
        loop_en = lp;
        start   = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        for (int k = 0; k < exp_p.size(); k++) begin
            if (k == clear_at) loop_en = 1'b0;
            check($sformatf("%s pitch slot %0d", tag, k), 32'(pitch), exp_p[k]);
            check($sformatf("%s idx slot %0d", tag, k), 32'(note_idx), exp_i[k]);
            tick();
        end
        check({tag, " end pitch"}, 32'(pitch), 0);
        check({tag, " end busy"}, 32'(busy), 0);
    endtask

    initial begin
        int ns0, d0;

        vecs[0] = '{len: 7'd0,  stop: 1'b0, exp_busy: 1'b0};
        vecs[1] = '{len: 7'd33, stop: 1'b0, exp_busy: 1'b0};
        vecs[2] = '{len: 7'd63, stop: 1'b0, exp_busy: 1'b0};
        vecs[3] = '{len: 7'd1,  stop: 1'b1, exp_busy: 1'b0};
        vecs[4] = '{len: 7'd3,  stop: 1'b1, exp_busy: 1'b0};
        vecs[5] = '{len: 7'd1,  stop: 1'b0, exp_busy: 1'b1};
        vecs[6] = '{len: 7'd32, stop: 1'b0, exp_busy: 1'b1};

        repeat (3) cycle();
        check("reset pitch", 32'(pitch), 0);
        check("reset note_start", 32'(note_start), 0);
        check("reset note_idx", 32'(note_idx), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        reset = 1'b1;
        cycle();

        // start acceptance: illegal lengths and start+stop must leave the sequencer idle
        for (int v = 0; v < 7; v++) begin
            len   = vecs[v].len;
            start = 1'b1;
            stop  = vecs[v].stop;
            cycle();
            start = 1'b0;
            stop  = 1'b0;
            check($sformatf("vec %0d busy", v), 32'(busy), 32'(vecs[v].exp_busy));
            if (busy === 1'b1) begin
                stop = 1'b1;
                cycle();
                stop = 1'b0;
                check($sformatf("vec %0d stopped busy", v), 32'(busy), 0);
                check($sformatf("vec %0d stopped pitch", v), 32'(pitch), 0);
            end
            cycle();
        end

        write_note(0, 199, 4);
        write_note(1, 177, 2);
        write_note(2, 158, 3);

        ns0 = ns_cnt; d0 = done_cnt;
        expand(3, 1);
        play(3, 1'b0, -1, "basic");
        check("basic note_start count", ns_cnt - ns0, 3);
        check("basic done count", done_cnt - d0, 1);

        // loop twice, drop loop_en during note 1 of the second pass
        ns0 = ns_cnt; d0 = done_cnt;
        expand(3, 2);
        play(3, 1'b1, 9 + 4, "loop");
        check("loop note_start count", ns_cnt - ns0, 6);
        check("loop done count", done_cnt - d0, 1);

        // stop in the middle of note 1
        d0 = done_cnt;
        len = 7'd3; loop_en = 1'b0;
        start = 1'b1; cycle(); start = 1'b0; cycle();
        repeat (5) tick();
        check("stop pre pitch", 32'(pitch), 177);
        stop = 1'b1; cycle(); stop = 1'b0;
        check("stop pitch", 32'(pitch), 0);
        check("stop busy", 32'(busy), 0);
        check("stop note_idx", 32'(note_idx), 0);
        check("stop done", 32'(done), 0);
        repeat (20) cycle();
        check("stop done count", done_cnt - d0, 0);

        // full-depth table, one tick per note, entry 5 has a zero duration
        for (int i = 0; i < TABLE_DEPTH; i++) write_note(i, i + 1, (i == 5) ? 0 : 1);
        ns0 = ns_cnt; d0 = done_cnt;
        expand(32, 1);
        play(32, 1'b0, -1, "len32");
        check("len32 note_start count", ns_cnt - ns0, 32);
        check("len32 done count", done_cnt - d0, 1);

        // asynchronous reset between edges, then replay from the preserved table
        write_note(0, 199, 4);
        write_note(1, 177, 2);
        write_note(2, 158, 3);
        len = 7'd3; loop_en = 1'b0;
        start = 1'b1; cycle(); start = 1'b0; cycle();
        repeat (2) tick();
        check("pre-reset busy", 32'(busy), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async reset pitch", 32'(pitch), 0);
        check("async reset busy", 32'(busy), 0);
        check("async reset note_idx", 32'(note_idx), 0);
        check("async reset note_start", 32'(note_start), 0);
        check("async reset done", 32'(done), 0);
        cycle();
        reset = 1'b1;
        cycle();
        expand(3, 1);
        play(3, 1'b0, -1, "replay");

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) write_note(i, $urandom_range(0, 511), $urandom_range(0, 3));
            ns0 = ns_cnt; d0 = done_cnt;
            expand(n, 1);
            play(n, 1'b0, -1, $sformatf("rand%0d", r));
            check($sformatf("rand%0d note_start count", r), ns_cnt - ns0, n);
            check($sformatf("rand%0d done count", r), done_cnt - d0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
